// File: rtl/victim_wb_buffer_if.sv
// victim_wb_buffer_if
// Bundles the signals between the victim cache, the write-back buffer and
// memory.
//   evict_*   : eviction offer from the victim cache (valid/ready, dirty, tag, data)
//   lookup_*  : combinational forwarding lookup from the cache miss path
//   mem_*     : write-back request to memory (req/ack, tag, data)
//   flush_i, empty_o, flush_done_o : drain control and status
// The buffer itself connects through the slave modport. Its environment,
// which is the cache, memory and flush controller, uses the master modport.
interface victim_wb_buffer_if #(
  parameter int DCACHE_LINE_WIDTH = 128,
  parameter int DCACHE_TAG_BITS   = 23
);
  logic                         evict_valid_i;
  logic                         evict_ready_o;
  logic                         evict_dirty_i;
  logic [DCACHE_TAG_BITS-1:0]   evict_tag_i;
  logic [DCACHE_LINE_WIDTH-1:0] evict_data_i;
  logic [DCACHE_TAG_BITS-1:0]   lookup_tag_i;
  logic                         lookup_hit_o;
  logic [DCACHE_LINE_WIDTH-1:0] lookup_data_o;
  logic                         mem_req_o;
  logic [DCACHE_TAG_BITS-1:0]   mem_tag_o;
  logic [DCACHE_LINE_WIDTH-1:0] mem_data_o;
  logic                         mem_ack_i;
  logic                         flush_i;
  logic                         empty_o;
  logic                         flush_done_o;

  modport master (
    output evict_valid_i, evict_dirty_i, evict_tag_i, evict_data_i,
    output lookup_tag_i, mem_ack_i, flush_i,
    input  evict_ready_o, lookup_hit_o, lookup_data_o,
    input  mem_req_o, mem_tag_o, mem_data_o, empty_o, flush_done_o
  );

  modport slave (
    input  evict_valid_i, evict_dirty_i, evict_tag_i, evict_data_i,
    input  lookup_tag_i, mem_ack_i, flush_i,
    output evict_ready_o, lookup_hit_o, lookup_data_o,
    output mem_req_o, mem_tag_o, mem_data_o, empty_o, flush_done_o
  );
endinterface

// File: rtl/victim_wb_buffer.sv
// victim_wb_buffer
// Write-back buffer behind the data-cache victim cache. Dirty evictions are
// queued in a circular FIFO and drained to memory over a req/ack handshake.
// Clean evictions are dropped. A combinational lookup forwards buffered lines
// back to the cache miss path.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : victim_wb_buffer_if.slave, which carries the eviction, lookup,
//         memory and flush signals
//
// state  | meaning
// S_IDLE | no request outstanding; move to S_REQ when entries are queued
// S_REQ  | head entry presented to memory, waiting for mem_ack_i
module victim_wb_buffer #(
  parameter int DCACHE_LINE_WIDTH = 128,
  parameter int DCACHE_TAG_BITS   = 23,
  parameter int WB_DEPTH          = 4
) (
  input  logic               clk,
  input  logic               rst,
  victim_wb_buffer_if.slave  bus
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = $clog2(WB_DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic {S_IDLE, S_REQ} state_t;

  logic [WB_DEPTH-1:0]          valid_q;
  logic [DCACHE_TAG_BITS-1:0]   tag_q  [WB_DEPTH];
  logic [DCACHE_LINE_WIDTH-1:0] data_q [WB_DEPTH];
  ptr_t                         wr_ptr, rd_ptr;
  logic [CW-1:0]                count, count_nxt;
  logic                         full_q;
  logic                         flush_pending;
  state_t                       state, state_nxt;

  ptr_t age_idx [WB_DEPTH];
  logic lk_hit, mg_hit;
  ptr_t lk_idx, mg_idx;
  logic mem_req;
  logic push_dirty, do_merge, do_append, do_ack, idle_empty;

  // age_idx[0] is the oldest entry (head). Higher indices are younger.
  always_comb begin
    for (int i = 0; i < WB_DEPTH; i++) age_idx[i] = rd_ptr + ptr_t'(i);
  end

  // Scan oldest to youngest so that the youngest match wins. The in-flight
  // head is excluded as a merge target, because memory is already sampling
  // its data.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    mg_hit = 1'b0;
    mg_idx = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (valid_q[age_idx[i]] && tag_q[age_idx[i]] == bus.lookup_tag_i) begin
        lk_hit = 1'b1;
        lk_idx = age_idx[i];
      end
      if (valid_q[age_idx[i]] && tag_q[age_idx[i]] == bus.evict_tag_i &&
          !(i == 0 && state == S_REQ)) begin
        mg_hit = 1'b1;
        mg_idx = age_idx[i];
      end
    end
  end

  assign push_dirty = bus.evict_valid_i && !full_q && bus.evict_dirty_i;
  assign do_merge   = push_dirty && mg_hit;
  assign do_append  = push_dirty && !mg_hit;
  assign do_ack     = (state == S_REQ) && bus.mem_ack_i;
  assign count_nxt  = count + CW'(do_append) - CW'(do_ack);
  assign idle_empty = (count == '0) && (state == S_IDLE);

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    case (state)
      S_IDLE: if (count != '0) state_nxt = S_REQ;
      S_REQ: begin
        mem_req = 1'b1;
        if (bus.mem_ack_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      valid_q       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      full_q        <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      // Full is registered from the next count, so ready never depends
      // combinationally on mem_ack_i.
      full_q <= (count_nxt == CW'(WB_DEPTH));
      if (do_ack) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + ptr_t'(1);
      end
      if (do_append) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + ptr_t'(1);
      end
      flush_pending <= bus.flush_i | (flush_pending & ~idle_empty);
    end
  end

  // The tag and data arrays have no reset. The valid bits gate them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_append) begin
        tag_q[wr_ptr]  <= bus.evict_tag_i;
        data_q[wr_ptr] <= bus.evict_data_i;
      end else if (do_merge) begin
        data_q[mg_idx] <= bus.evict_data_i;
      end
    end
  end

  assign bus.evict_ready_o = !full_q;
  assign bus.lookup_hit_o  = lk_hit;
  assign bus.lookup_data_o = lk_hit ? data_q[lk_idx] : '0;
  assign bus.mem_req_o     = mem_req;
  assign bus.mem_tag_o     = mem_req ? tag_q[rd_ptr] : '0;
  assign bus.mem_data_o    = mem_req ? data_q[rd_ptr] : '0;
  assign bus.empty_o       = idle_empty;
  assign bus.flush_done_o  = flush_pending && idle_empty;
endmodule

// File: tb/tb_victim_wb_buffer.sv
// Testbench for victim_wb_buffer. Expected write-backs are queued when the
// stimulus is issued, and a monitor pops and compares them whenever memory
// acknowledges a request.
module tb_victim_wb_buffer;
  localparam int LW = 128;
  localparam int TW = 23;
  localparam int D  = 4;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [LW-1:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  victim_wb_buffer_if #(.DCACHE_LINE_WIDTH(LW), .DCACHE_TAG_BITS(TW)) bus();

  victim_wb_buffer #(.DCACHE_LINE_WIDTH(LW), .DCACHE_TAG_BITS(TW), .WB_DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  wb_t exp_q[$];
  wb_t mon_e;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] pat(input logic [31:0] x);
    return {4{x}};
  endfunction

  // Scoreboard monitor: a write-back completes when req and ack are both high.
  always @(negedge clk) begin
    if (!rst && bus.mem_req_o && bus.mem_ack_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_unexpected actual_tag=%0h required=none", bus.mem_tag_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("drain_tag", LW'(bus.mem_tag_o), LW'(mon_e.tag));
        check("drain_data", bus.mem_data_o, mon_e.data);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic dirty, input logic [TW-1:0] tag,
                      input logic [LW-1:0] data, input bit expect_wb);
    wb_t e;
    bus.evict_valid_i = 1'b1;
    bus.evict_dirty_i = dirty;
    bus.evict_tag_i   = tag;
    bus.evict_data_i  = data;
    if (expect_wb) begin
      e.tag  = tag;
      e.data = data;
      exp_q.push_back(e);
    end
    tick();
    bus.evict_valid_i = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (!bus.mem_req_o && k < 30) begin
      tick();
      k++;
    end
    check(name, LW'(bus.mem_req_o), LW'(1));
  endtask

  task automatic ack(input string name);
    wait_req(name);
    bus.mem_ack_i = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
  endtask

  // A dirty push lands in the same cycle as the ack of the in-flight head.
  task automatic push_ack(input string name, input logic [TW-1:0] tag, input logic [LW-1:0] data);
    wb_t e;
    wait_req(name);
    bus.evict_valid_i = 1'b1;
    bus.evict_dirty_i = 1'b1;
    bus.evict_tag_i   = tag;
    bus.evict_data_i  = data;
    bus.mem_ack_i     = 1'b1;
    e.tag  = tag;
    e.data = data;
    exp_q.push_back(e);
    tick();
    bus.evict_valid_i = 1'b0;
    bus.mem_ack_i     = 1'b0;
  endtask

  task automatic look(input string name, input logic [TW-1:0] tag,
                      input logic hit, input logic [LW-1:0] data);
    bus.lookup_tag_i = tag;
    #1;
    check({name, "_hit"}, LW'(bus.lookup_hit_o), LW'(hit));
    check({name, "_data"}, bus.lookup_data_o, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.evict_valid_i = 1'b0;
    bus.evict_dirty_i = 1'b0;
    bus.evict_tag_i   = '0;
    bus.evict_data_i  = '0;
    bus.lookup_tag_i  = '0;
    bus.mem_ack_i     = 1'b0;
    bus.flush_i       = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;

    // Reset values
    check("rst_ready", LW'(bus.evict_ready_o), LW'(1));
    check("rst_req", LW'(bus.mem_req_o), LW'(0));
    check("rst_tag", LW'(bus.mem_tag_o), LW'(0));
    check("rst_data", bus.mem_data_o, '0);
    check("rst_empty", LW'(bus.empty_o), LW'(1));
    check("rst_flush_done", LW'(bus.flush_done_o), LW'(0));
    look("rst_lookup", 23'h0, 1'b0, '0);

    // Push 0x1A, then one cycle of latency to the request, then an ack
    push(1'b1, 23'h1A, {32{4'hA}}, 1'b1);
    check("t1_req_latency", LW'(bus.mem_req_o), LW'(0));
    check("t1_not_empty", LW'(bus.empty_o), LW'(0));
    tick();
    check("t1_req", LW'(bus.mem_req_o), LW'(1));
    check("t1_tag", LW'(bus.mem_tag_o), LW'(23'h1A));
    tick(2);
    check("t1_tag_held", LW'(bus.mem_tag_o), LW'(23'h1A));
    bus.mem_ack_i = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    check("t1_empty", LW'(bus.empty_o), LW'(1));
    check("t1_req_off", LW'(bus.mem_req_o), LW'(0));
    check("t1_tag_zero", LW'(bus.mem_tag_o), LW'(0));

    // Clean eviction is dropped
    push(1'b0, 23'h05, pat(32'h5555_0005), 1'b0);
    check("t2_count", LW'(dut.count), LW'(0));
    tick();
    check("t2_req", LW'(bus.mem_req_o), LW'(0));
    look("t2_lookup", 23'h05, 1'b0, '0);

    // Fill to capacity, then backpressure and drain order
    for (int t = 1; t <= 4; t++) push(1'b1, TW'(t), pat(32'h100 + 32'(t)), 1'b1);
    check("t3_full_ready", LW'(bus.evict_ready_o), LW'(0));
    look("t3_lookup3", 23'h3, 1'b1, pat(32'h103));
    push(1'b1, 23'h5, pat(32'h105), 1'b0);
    check("t3_no_accept", LW'(dut.count), LW'(4));
    look("t3_lookup5", 23'h5, 1'b0, '0);
    wait_req("t3_req1");
    bus.mem_ack_i = 1'b1;
    #1;
    check("t3_ready_during_ack", LW'(bus.evict_ready_o), LW'(0));
    tick();
    bus.mem_ack_i = 1'b0;
    check("t3_ready_after_ack", LW'(bus.evict_ready_o), LW'(1));
    ack("t3_req2");
    ack("t3_req3");
    ack("t3_req4");
    check("t3_empty", LW'(bus.empty_o), LW'(1));

    // Merge into a queued entry, and append when only the in-flight head matches
    push(1'b1, 23'h7, pat(32'hA7A7_A7A7), 1'b1);
    wait_req("t4_req7");
    check("t4_head7", LW'(bus.mem_tag_o), LW'(23'h7));
    push(1'b1, 23'h9, pat(32'h9999_9999), 1'b0);
    push(1'b1, 23'h9, pat(32'hBBBB_BBBB), 1'b1);
    check("t4_count_merge", LW'(dut.count), LW'(2));
    look("t4_lookup9", 23'h9, 1'b1, pat(32'hBBBB_BBBB));
    push(1'b1, 23'h7, pat(32'hC7C7_C7C7), 1'b1);
    check("t4_count_append", LW'(dut.count), LW'(3));
    look("t4_lookup7", 23'h7, 1'b1, pat(32'hC7C7_C7C7));
    check("t4_head_data", bus.mem_data_o, pat(32'hA7A7_A7A7));
    ack("t4_a1");
    ack("t4_a2");
    ack("t4_a3");

    // Simultaneous push and ack at count 2 with wr_ptr wrapping from 3 to 0 to 1
    push(1'b1, 23'h11, pat(32'h11), 1'b1);
    push(1'b1, 23'h12, pat(32'h12), 1'b1);
    push(1'b1, 23'h13, pat(32'h13), 1'b1);
    ack("t5_a11");
    push_ack("t5_pa14", 23'h14, pat(32'h14));
    check("t5_count_a", LW'(dut.count), LW'(2));
    push_ack("t5_pa15", 23'h15, pat(32'h15));
    check("t5_count_b", LW'(dut.count), LW'(2));
    check("t5_wr_wrap", LW'(dut.wr_ptr), LW'(1));
    ack("t5_a14");
    ack("t5_a15");
    check("t5_rd_wrap", LW'(dut.rd_ptr), LW'(1));
    check("t5_empty", LW'(bus.empty_o), LW'(1));

    // Flush with three entries pending
    push(1'b1, 23'h21, pat(32'h21), 1'b1);
    push(1'b1, 23'h22, pat(32'h22), 1'b1);
    push(1'b1, 23'h23, pat(32'h23), 1'b1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("t6_done_early", LW'(bus.flush_done_o), LW'(0));
    ack("t6_a1");
    ack("t6_a2");
    check("t6_done_before_last", LW'(bus.flush_done_o), LW'(0));
    ack("t6_a3");
    check("t6_done", LW'(bus.flush_done_o), LW'(1));
    tick();
    check("t6_done_once", LW'(bus.flush_done_o), LW'(0));
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("t6_empty_flush_done", LW'(bus.flush_done_o), LW'(1));
    tick();
    check("t6_empty_flush_once", LW'(bus.flush_done_o), LW'(0));

    // Reset while a request is outstanding abandons it
    push(1'b1, 23'h31, pat(32'h31), 1'b0);
    wait_req("t7_req");
    rst = 1'b1;
    tick();
    check("t7_req_dropped", LW'(bus.mem_req_o), LW'(0));
    check("t7_empty", LW'(bus.empty_o), LW'(1));
    rst = 1'b0;
    tick();
    check("t7_no_resume", LW'(bus.mem_req_o), LW'(0));
    look("t7_lookup", 23'h31, 1'b0, '0);

    check("sb_drained", LW'(exp_q.size()), LW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
